exu_div_wb_ctl: RTL and testbench

EXU_DIV_WB_CTL -- requirements
Module: exu_div_wb_ctl

---
 rtl/veer_types.sv | 20 ++
 rtl/rvdff.sv | 24 ++
 rtl/rvdffs.sv | 24 ++
 rtl/exu_div_wb_ctl.sv | 145 ++++++++++++++
 tb/tb_exu_div_wb_ctl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/veer_types.sv
// Shared types and defaults for the EXU divide writeback controller.
package veer_types;

    localparam int unsigned EXU_DIV_LATENCY_DEF = 36;
    localparam int unsigned EXU_DIV_TIMEOUT_DEF = 48;
    localparam int unsigned EXU_DIV_CNT_W       = 6;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StDrain = 2'd2,
        StHold  = 2'd3
    } exu_div_wb_state_t;

    // Cycle counter increment that sticks at all-ones.
    function automatic logic [EXU_DIV_CNT_W-1:0] sat_inc(input logic [EXU_DIV_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rvdff.sv
// Plain D flop vector with asynchronous active-low reset.
module rvdff #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             clk,
    input  logic             rst_l,
    input  logic             scan_mode,
    output logic [WIDTH-1:0] dout
);

    // Reset is held inactive in scan mode so the chain can shift.
    logic rst_eff_l;
    assign rst_eff_l = rst_l | scan_mode;

    always_ff @(posedge clk or negedge rst_eff_l) begin
        if (!rst_eff_l) begin
            dout <= '0;
        end else begin
            dout <= din;
        end
    end

endmodule

// File: rtl/rvdffs.sv
// D flop vector with load enable and asynchronous active-low reset.
module rvdffs #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             clk,
    input  logic             rst_l,
    input  logic             scan_mode,
    output logic [WIDTH-1:0] dout
);

    logic rst_eff_l;
    assign rst_eff_l = rst_l | scan_mode;

    always_ff @(posedge clk or negedge rst_eff_l) begin
        if (!rst_eff_l) begin
            dout <= '0;
        end else if (en) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/exu_div_wb_ctl.sv
// Tracks one outstanding divide from issue to writeback, checking the divider's
// fixed latency and abandoning it after a timeout.
module exu_div_wb_ctl
    import veer_types::*;
#(
    parameter int unsigned DIV_LATENCY = EXU_DIV_LATENCY_DEF,
    parameter int unsigned TIMEOUT     = EXU_DIV_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        scan_mode,
    input  logic        div_valid,
    input  logic [4:0]  div_rd,
    input  logic        flush_lower,
    input  logic        div_finish,
    input  logic [31:0] div_result,
    input  logic        wb_grant,
    output logic        wb_req,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        div_busy,
    output logic        lat_err,
    output logic        tmo_err
);

    localparam logic [EXU_DIV_CNT_W-1:0] LatCnt = EXU_DIV_CNT_W'(DIV_LATENCY);
    localparam logic [EXU_DIV_CNT_W-1:0] TmoCnt = EXU_DIV_CNT_W'(TIMEOUT);

    exu_div_wb_state_t        state_q, state_d;
    logic [1:0]               state_raw;
    logic [EXU_DIV_CNT_W-1:0] count_q, count_d;
    logic [4:0]               rd_q;
    logic                     issue_en;
    logic                     cap_en;

    assign state_q = exu_div_wb_state_t'(state_raw);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        issue_en = 1'b0;
        cap_en   = 1'b0;
        lat_err  = 1'b0;
        tmo_err  = 1'b0;
        div_busy = 1'b1;
        unique case (state_q)
            StIdle: begin
                div_busy = 1'b0;
                if (div_valid && !flush_lower) begin
                    issue_en = 1'b1;
                    count_d  = '0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                count_d = sat_inc(count_q);
                // Timeout takes priority over a finish landing in the same cycle.
                if (count_q == TmoCnt) begin
                    tmo_err = 1'b1;
                    state_d = StIdle;
                end else if (div_finish && flush_lower) begin
                    state_d = StIdle;
                end else if (div_finish) begin
                    cap_en  = 1'b1;
                    lat_err = (count_q != LatCnt);
                    state_d = StHold;
                end else if (flush_lower) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                count_d = sat_inc(count_q);
                if (count_q == TmoCnt) begin
                    tmo_err = 1'b1;
                    state_d = StIdle;
                end else if (div_finish) begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                // Result is already past the flush point; only the grant releases it.
                if (wb_grant) begin
                    div_busy = 1'b0;
                    state_d  = StIdle;
                    if (div_valid && !flush_lower) begin
                        issue_en = 1'b1;
                        count_d  = '0;
                        state_d  = StWait;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign wb_req = (state_q == StHold);

    rvdff #(.WIDTH(2)) u_state_ff (
        .din       (state_d),
        .clk       (clk),
        .rst_l     (rst_l),
        .scan_mode (scan_mode),
        .dout      (state_raw)
    );

    rvdff #(.WIDTH(EXU_DIV_CNT_W)) u_count_ff (
        .din       (count_d),
        .clk       (clk),
        .rst_l     (rst_l),
        .scan_mode (scan_mode),
        .dout      (count_q)
    );

    rvdffs #(.WIDTH(5)) u_rd_ff (
        .din       (div_rd),
        .en        (issue_en),
        .clk       (clk),
        .rst_l     (rst_l),
        .scan_mode (scan_mode),
        .dout      (rd_q)
    );

    // The writeback copy of rd only moves on capture, so a flushed or
    // back-to-back issue never disturbs the visible wb_rd.
    rvdffs #(.WIDTH(5)) u_wb_rd_ff (
        .din       (rd_q),
        .en        (cap_en),
        .clk       (clk),
        .rst_l     (rst_l),
        .scan_mode (scan_mode),
        .dout      (wb_rd)
    );

    rvdffs #(.WIDTH(32)) u_wb_data_ff (
        .din       (div_result),
        .en        (cap_en),
        .clk       (clk),
        .rst_l     (rst_l),
        .scan_mode (scan_mode),
        .dout      (wb_data)
    );

endmodule

// File: tb/tb_exu_div_wb_ctl.sv
// Directed bench for exu_div_wb_ctl: vector table plus back-to-back and reset sequences.
module tb_exu_div_wb_ctl;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        scan_mode;
    logic        div_valid;
    logic [4:0]  div_rd;
    logic        flush_lower;
    logic        div_finish;
    logic [31:0] div_result;
    logic        wb_grant;
    logic        wb_req;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        div_busy;
    logic        lat_err;
    logic        tmo_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    exu_div_wb_ctl dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .scan_mode   (scan_mode),
        .div_valid   (div_valid),
        .div_rd      (div_rd),
        .flush_lower (flush_lower),
        .div_finish  (div_finish),
        .div_result  (div_result),
        .wb_grant    (wb_grant),
        .wb_req      (wb_req),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .div_busy    (div_busy),
        .lat_err     (lat_err),
        .tmo_err     (tmo_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        int          fin_at;    // count at which div_finish is driven, -1 = never
        int          flush_at;  // count at which flush_lower is driven, -1 = never
        int          gnt;       // HOLD cycle (1-based) carrying wb_grant
        int          e_busy;
        int          e_req;
        int          e_lat;
        int          e_tmo;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        div_valid   = 1'b0;
        div_rd      = 5'd0;
        flush_lower = 1'b0;
        div_finish  = 1'b0;
        div_result  = 32'h0;
        wb_grant    = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int c;
        int busy_n;
        int req_n;
        int lat_n;
        int tmo_n;
        bit done;
        string tag;
        tag = $sformatf("v%0d", idx);
        idle_inputs();
        div_valid = 1'b1;
        div_rd    = v.rd;
        #2;
        chk({tag, "_issue_busy"}, 32'(div_busy), 32'd0);
        tick();
        c = 0; busy_n = 0; req_n = 0; lat_n = 0; tmo_n = 0; done = 1'b0;
        while (!done && c < 150) begin
            // A second issue at count 2 lands while busy and must be ignored.
            div_valid   = (c == 2);
            div_rd      = (c == 2) ? 5'd0 : v.rd;
            div_finish  = (c == v.fin_at);
            div_result  = (c == v.fin_at) ? v.res : 32'hdead_beef;
            flush_lower = (c == v.flush_at);
            wb_grant    = wb_req && (req_n + 1 == v.gnt);
            #2;
            if (wb_req)  req_n++;
            if (lat_err) lat_n++;
            if (tmo_err) tmo_n++;
            if (div_busy) busy_n++;
            else          done = 1'b1;
            tick();
            c++;
        end
        idle_inputs();
        #2;
        chk({tag, "_done"},       32'(done),   32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(v.e_busy));
        chk({tag, "_req_cycles"},  32'(req_n),  32'(v.e_req));
        chk({tag, "_lat_pulses"},  32'(lat_n),  32'(v.e_lat));
        chk({tag, "_tmo_pulses"},  32'(tmo_n),  32'(v.e_tmo));
        chk({tag, "_wb_req_end"},  32'(wb_req), 32'd0);
        chk({tag, "_wb_rd"},       32'(wb_rd),  32'(v.e_rd));
        chk({tag, "_wb_data"},     wb_data,     v.e_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        //           rd     res            fin flush gnt busy req lat tmo e_rd   e_data
        vecs[0] = '{5'd5,  32'h0000_0007, 36, -1,   2,  38,  2,  0,  0,  5'd5,  32'h0000_0007};
        vecs[1] = '{5'd3,  32'h0000_1234, 20, -1,   1,  21,  1,  1,  0,  5'd3,  32'h0000_1234};
        vecs[2] = '{5'd7,  32'h0000_0bad, 36, 10,   1,  37,  0,  0,  0,  5'd3,  32'h0000_1234};
        vecs[3] = '{5'd11, 32'h0000_0011, -1, -1,   1,  49,  0,  0,  1,  5'd3,  32'h0000_1234};
        vecs[4] = '{5'd12, 32'h0000_0c0c,  5,  5,   1,   6,  0,  0,  0,  5'd3,  32'h0000_1234};
        vecs[5] = '{5'd13, 32'h0000_0055, 40, -1,   3,  43,  3,  1,  0,  5'd13, 32'h0000_0055};
        vecs[6] = '{5'd14, 32'h0000_0e0e, -1,  3,   1,  49,  0,  0,  1,  5'd13, 32'h0000_0055};
        vecs[7] = '{5'd31, 32'hffff_ffff, 36, -1,   1,  37,  1,  0,  0,  5'd31, 32'hffff_ffff};

        scan_mode = 1'b0;
        rst_l     = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_req",   32'(wb_req),   32'd0);
        chk("rst_wb_rd",    32'(wb_rd),    32'd0);
        chk("rst_wb_data",  wb_data,       32'd0);
        chk("rst_div_busy", 32'(div_busy), 32'd0);
        chk("rst_lat_err",  32'(lat_err),  32'd0);
        chk("rst_tmo_err",  32'(tmo_err),  32'd0);
        rst_l = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back: grant and new issue in the same HOLD cycle.
        idle_inputs();
        div_valid = 1'b1;
        div_rd    = 5'd4;
        tick();
        div_valid = 1'b0;
        repeat (36) tick();
        div_finish = 1'b1;
        div_result = 32'h0000_000a;
        #2;
        chk("b2b_first_lat", 32'(lat_err), 32'd0);
        tick();
        div_finish = 1'b0;
        wb_grant   = 1'b1;
        div_valid  = 1'b1;
        div_rd     = 5'd9;
        #2;
        chk("b2b_grant_busy", 32'(div_busy), 32'd0);
        chk("b2b_grant_req",  32'(wb_req),   32'd1);
        tick();
        idle_inputs();
        #2;
        chk("b2b_wait_busy",  32'(div_busy), 32'd1);
        chk("b2b_wait_req",   32'(wb_req),   32'd0);
        chk("b2b_hold_rd",    32'(wb_rd),    32'd4);
        chk("b2b_hold_data",  wb_data,       32'h0000_000a);
        repeat (36) tick();
        div_finish = 1'b1;
        div_result = 32'h0000_0099;
        #2;
        chk("b2b_second_lat", 32'(lat_err), 32'd0);
        tick();
        div_finish = 1'b0;
        #2;
        chk("b2b_second_req",  32'(wb_req), 32'd1);
        chk("b2b_second_rd",   32'(wb_rd),  32'd9);
        chk("b2b_second_data", wb_data,     32'h0000_0099);
        wb_grant = 1'b1;
        tick();
        wb_grant = 1'b0;
        #2;
        chk("b2b_end_req", 32'(wb_req), 32'd0);

        // Asynchronous reset in HOLD, then a stray finish.
        tick();
        div_valid = 1'b1;
        div_rd    = 5'd6;
        tick();
        div_valid = 1'b0;
        repeat (36) tick();
        div_finish = 1'b1;
        div_result = 32'h0000_0066;
        tick();
        div_finish = 1'b0;
        #2;
        chk("rsth_req_before", 32'(wb_req), 32'd1);
        rst_l = 1'b0;
        #1;
        chk("rsth_req",  32'(wb_req),   32'd0);
        chk("rsth_rd",   32'(wb_rd),    32'd0);
        chk("rsth_data", wb_data,       32'd0);
        chk("rsth_busy", 32'(div_busy), 32'd0);
        tick();
        tick();
        rst_l = 1'b1;
        tick();
        div_finish = 1'b1;
        div_result = 32'h0000_0077;
        #2;
        chk("stray_fin_lat",  32'(lat_err),  32'd0);
        chk("stray_fin_busy", 32'(div_busy), 32'd0);
        tick();
        div_finish = 1'b0;
        #2;
        chk("stray_fin_req",  32'(wb_req), 32'd0);
        chk("stray_fin_data", wb_data,     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
